// File: rtl/led_pwm_pkg.sv
// Shared definitions for the LED PWM bank: channel modes, register map and field positions.
package led_pwm_pkg;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_ON    = 2'd1,
      MODE_PWM   = 2'd2,
      MODE_BLINK = 2'd3
   } mode_e;

   localparam int REG_CTRL    = 0;
   localparam int REG_PRESC   = 1;
   localparam int REG_STATUS  = 2;
   localparam int REG_CH_BASE = 4;

   localparam int CTRL_EN  = 0;
   localparam int CTRL_INV = 1;
   localparam int CTRL_IRQ = 2;

   localparam int CH_MODE_LSB = 0;
   localparam int CH_DUTY_LSB = 8;
   localparam int CH_HALF_LSB = 16;

   function automatic logic [31:0] field_mask(input int width, input int lsb);
      return ((32'd1 << width) - 32'd1) << lsb;
   endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: mode decode, PWM compare against the shared counter, blink counter and phase.
module led_pwm_channel
   import led_pwm_pkg::*;
#(
   parameter int PWM_BITS   = 8,
   parameter int BLINK_BITS = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [PWM_BITS-1:0] pwm_cnt,
   input  logic                period_end,
   input  logic [31:0]         cfg,
   input  logic                cfg_wr,
   output logic                chan_out
);

   localparam logic [31:0] USED_MASK = field_mask(2, CH_MODE_LSB)
                                     | field_mask(PWM_BITS, CH_DUTY_LSB)
                                     | field_mask(BLINK_BITS, CH_HALF_LSB);

   mode_e                 mode;
   logic [PWM_BITS-1:0]   duty;
   logic [BLINK_BITS-1:0] half;
   logic [BLINK_BITS-1:0] half_eff;
   logic [BLINK_BITS-1:0] blink_cnt;
   logic [BLINK_BITS-1:0] cnt_inc;
   logic                  blink_phase;
   logic                  unused_cfg;

   assign mode       = mode_e'(cfg[CH_MODE_LSB +: 2]);
   assign duty       = cfg[CH_DUTY_LSB +: PWM_BITS];
   assign half       = cfg[CH_HALF_LSB +: BLINK_BITS];
   assign unused_cfg = ^(cfg & ~USED_MASK);

   // a half-period of 0 behaves like 1 so the blink never stalls
   assign half_eff = (half == '0) ? BLINK_BITS'(1) : half;
   assign cnt_inc  = blink_cnt + 1'b1;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
      end else if (cfg_wr) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
      end else if (mode == MODE_BLINK && period_end) begin
         if (cnt_inc == half_eff) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= cnt_inc;
         end
      end
   end

   always_comb begin
      chan_out = 1'b0;
      case (mode)
         MODE_OFF:   chan_out = 1'b0;
         MODE_ON:    chan_out = 1'b1;
         MODE_PWM:   chan_out = (pwm_cnt < duty);
         MODE_BLINK: chan_out = blink_phase;
         default:    chan_out = 1'b0;
      endcase
   end

endmodule

// File: rtl/led_pwm_bank.sv
// Avalon-MM LED controller with per-channel off/on/PWM/blink modes.
// Define LEDPWM_IRQ_EN to add the period interrupt (STATUS pending bit and irq port).
module led_pwm_bank
   import led_pwm_pkg::*;
#(
   parameter int NUM_CH     = 8,
   parameter int ADDR_W     = 4,
   parameter int PWM_BITS   = 8,
   parameter int PRESC_BITS = 16,
   parameter int BLINK_BITS = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] avs_address,
   input  logic              avs_read,
   input  logic              avs_write,
   input  logic [31:0]       avs_writedata,
   output logic [31:0]       avs_readdata,
   output logic              avs_readdatavalid,
   output logic [NUM_CH-1:0] led_out
`ifdef LEDPWM_IRQ_EN
   ,
   output logic              irq
`endif
);

   localparam logic [31:0] CH_MASK = field_mask(2, CH_MODE_LSB)
                                   | field_mask(PWM_BITS, CH_DUTY_LSB)
                                   | field_mask(BLINK_BITS, CH_HALF_LSB);

   logic [2:0]            ctrl;
   logic [PRESC_BITS-1:0] presc;
   logic [PRESC_BITS-1:0] presc_cnt;
   logic [PWM_BITS-1:0]   pwm_cnt;
   logic [31:0]           ch_reg [NUM_CH];
   logic [NUM_CH-1:0]     ch_wr;
   logic [NUM_CH-1:0]     chan;
   logic                  wr_ctrl;
   logic                  wr_presc;
   logic                  tick;
   logic                  period_end;
   logic [31:0]           rd_mux;
`ifdef LEDPWM_IRQ_EN
   logic                  wr_status;
   logic                  pending;
`endif

   assign wr_ctrl  = avs_write && (avs_address == ADDR_W'(REG_CTRL));
   assign wr_presc = avs_write && (avs_address == ADDR_W'(REG_PRESC));
`ifdef LEDPWM_IRQ_EN
   assign wr_status = avs_write && (avs_address == ADDR_W'(REG_STATUS));
`endif

   always_comb begin
      ch_wr = '0;
      for (int i = 0; i < NUM_CH; i++)
         ch_wr[i] = avs_write && (avs_address == ADDR_W'(REG_CH_BASE + i));
   end

   // read mux sees pre-write register values, so a same-cycle read returns old data
   always_comb begin
      rd_mux = '0;
      if (avs_address == ADDR_W'(REG_CTRL))
         rd_mux = {29'd0, ctrl};
      else if (avs_address == ADDR_W'(REG_PRESC))
         rd_mux = 32'(presc);
`ifdef LEDPWM_IRQ_EN
      else if (avs_address == ADDR_W'(REG_STATUS))
         rd_mux = {31'd0, pending};
`endif
      for (int i = 0; i < NUM_CH; i++)
         if (avs_address == ADDR_W'(REG_CH_BASE + i))
            rd_mux = ch_reg[i];
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ctrl              <= '0;
         presc             <= '0;
         avs_readdata      <= '0;
         avs_readdatavalid <= 1'b0;
         for (int i = 0; i < NUM_CH; i++)
            ch_reg[i] <= '0;
      end else begin
         if (wr_ctrl)
            ctrl <= avs_writedata[2:0];
         if (wr_presc)
            presc <= avs_writedata[PRESC_BITS-1:0];
         for (int i = 0; i < NUM_CH; i++)
            if (ch_wr[i])
               ch_reg[i] <= avs_writedata & CH_MASK;
         avs_readdatavalid <= avs_read;
         if (avs_read)
            avs_readdata <= rd_mux;
      end
   end

   // prescaler down-counter: tick on terminal count, giving a PRESC+1 clock period
   assign tick       = (presc_cnt == '0);
   assign period_end = tick && (pwm_cnt == '1);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         presc_cnt <= '0;
         pwm_cnt   <= '0;
      end else begin
         if (wr_presc)
            presc_cnt <= avs_writedata[PRESC_BITS-1:0];
         else if (tick)
            presc_cnt <= presc;
         else
            presc_cnt <= presc_cnt - 1'b1;
         if (tick)
            pwm_cnt <= pwm_cnt + 1'b1;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      led_pwm_channel #(
         .PWM_BITS   (PWM_BITS),
         .BLINK_BITS (BLINK_BITS)
      ) u_ch (
         .clk        (clk),
         .reset_n    (reset_n),
         .pwm_cnt    (pwm_cnt),
         .period_end (period_end),
         .cfg        (ch_reg[g]),
         .cfg_wr     (ch_wr[g]),
         .chan_out   (chan[g])
      );
   end

   always_ff @(posedge clk) begin
      if (!reset_n)
         led_out <= '0;
      else
         led_out <= ({NUM_CH{ctrl[CTRL_EN]}} & chan) ^ {NUM_CH{ctrl[CTRL_INV]}};
   end

`ifdef LEDPWM_IRQ_EN
   // a new period end outranks a simultaneous write-1-to-clear
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pending <= 1'b0;
         irq     <= 1'b0;
      end else begin
         if (period_end && ctrl[CTRL_IRQ])
            pending <= 1'b1;
         else if (wr_status && avs_writedata[0])
            pending <= 1'b0;
         irq <= pending & ctrl[CTRL_IRQ];
      end
   end
`endif

endmodule

// File: doc/led_pwm_bank.md
Name: led_pwm_bank

Overview:
- Parametrised Avalon-MM LED controller for the Nios SoC. It is the next generation of the plain LED PIO, which only exposes static on/off bits.
- Drives NUM_CH LEDs. Each channel is independently set to one of four modes: off, on, PWM dimming, or blink.
- Sits as a Qsys slave on the Nios data master. Its led_out port connects at the board top to LEDG/LEDR.

Parameters:
- NUM_CH, 8, number of LED channels (1..28).
- ADDR_W, 4, word-address width; NUM_CH+4 <= 2**ADDR_W is required.
- PWM_BITS, 8, PWM counter/duty width (4..12).
- PRESC_BITS, 16, prescaler reload width.
- BLINK_BITS, 8, blink half-period width, counted in PWM periods.

Ports:
- clk, input, 1, system clock; all logic on its rising edge.
- reset_n, input, 1, synchronous active-low reset.
- avs_address, input, ADDR_W, word address.
- avs_read, input, 1, read strobe.
- avs_write, input, 1, write strobe.
- avs_writedata, input, 32, write data.
- avs_readdata, output, 32, registered read data.
- avs_readdatavalid, output, 1, read data valid.
- led_out, output, NUM_CH, registered LED drive.
- irq, output, 1, period interrupt; present only with LEDPWM_IRQ_EN.

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset values: all registers 0; led_out=0, avs_readdata=0, avs_readdatavalid=0, irq=0.
- Register map (word addresses):
  - 0 CTRL: bit0 global enable, bit1 invert, bit2 irq enable.
  - 1 PRESC: [PRESC_BITS-1:0].
  - 2 STATUS: bit0 irq pending, write-1-to-clear.
  - 3 reserved.
  - 4+i CH[i]: [1:0] mode (0 off, 1 on, 2 pwm, 3 blink); [8+PWM_BITS-1:8] duty; [16+BLINK_BITS-1:16] half-period.
- Bus interface:
  - No waitrequest.
  - Reads: avs_readdatavalid=1 exactly one cycle after avs_read; readdata registered. Unused bits read 0.
  - Unmapped addresses read 0; writes to them are ignored.
  - Read and write to the same address in the same cycle: the read returns the old value.
- Prescaler:
  - Down-counter reloads PRESC on reaching 0 and emits a 1-cycle tick at that point, so tick period = PRESC+1 clocks.
  - A write to PRESC loads the counter immediately.
- PWM counter:
  - pwm_cnt increments on tick and wraps from 2**PWM_BITS-1 to 0.
  - period_end = tick & (pwm_cnt == max).
- Channel output before the global stage:
  - Mode off: 0.
  - Mode on: 1.
  - Mode pwm: (pwm_cnt < duty). duty=0 gives constant 0; duty=max gives on for max of 2**PWM_BITS ticks.
  - Mode blink: per-channel counter increments on period_end. When it reaches the half-period value (0 treated as 1), the blink phase toggles and the counter clears.
  - Blink phase resets to 1 (on).
- A write to CH[i] clears channel i's blink counter and sets its phase to 1.
- Final output: led_out[i] <= (enable & chan[i]) ^ invert, registered.
  - Latency from a CH/CTRL write edge to led_out is 2 edges: register update, then output register.
- Reset mid-operation returns every register and counter to its reset value on the next edge, regardless of bus activity.

Optional Feature:
- Macro LEDPWM_IRQ_EN.
- Defined:
  - STATUS.bit0 sets on period_end when CTRL.bit2=1.
  - STATUS write with bit0=1 clears it; if set and clear occur in the same cycle, set wins.
  - irq = pending & CTRL.bit2, registered.
- Undefined:
  - irq port absent; STATUS reads 0; CTRL.bit2 is read/write but has no effect.

Decomposition:
- Package led_pwm_pkg holds:
  - mode enum (MODE_OFF/ON/PWM/BLINK);
  - register offsets (REG_CTRL=0, REG_PRESC=1, REG_STATUS=2, REG_CH_BASE=4);
  - CTRL bit indices;
  - CH field LSB constants.
- Sub-module led_pwm_channel holds the per-channel mode decode, PWM compare, and blink counter/phase. It takes inputs pwm_cnt, period_end, cfg, and cfg_wr, and outputs chan_out.
- led_pwm_channel is instantiated NUM_CH times in a generate loop.
- The top holds the bus interface, registers, prescaler, pwm_cnt, output stage, and irq.

Test Plan:
- Reset, then read all addresses -> every read returns 0 with readdatavalid one cycle after avs_read; led_out=0.
- CTRL=1, PRESC=0, CH0 = pwm duty 64 -> led_out[0] high 64 of every 256 clocks. Then PRESC=3 -> high 256 of every 1024 clocks.
- CH1 = blink half=2, PRESC=0 -> led_out[1] toggles every 512 clocks, starting high. Then rewrite CH1 mid-phase -> phase restarts high.
- CH2 = on, then CTRL=0 -> led_out=0 two edges after the write. Then CTRL=2 (invert, disabled) -> led_out all ones.
- With LEDPWM_IRQ_EN: CTRL=5, PRESC=0 -> irq rises after 256 clocks. STATUS write 1 in the same cycle as period_end -> pending stays 1. Clear later -> irq=0.
- Pull reset_n low for one cycle during PWM activity -> next edge led_out=0 and registers read 0; a write issued during reset is ignored.
